// File: rtl/demux8_reg_if.sv
// rtl/demux8_reg_if.sv - input stream and eight output channel bundle for demux8_reg
interface demux8_reg_if #(
  parameter int WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_sel;
  logic [WIDTH-1:0]     in_data;
  logic [7:0]           out_valid;
  logic [7:0]           out_ready;
  logic [8*WIDTH-1:0]   out_data;
  logic                 busy;

  // Producer and consumers side
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  // Demultiplexer side
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/demux8_reg.sv
// rtl/demux8_reg.sv - 1-to-8 registered demultiplexer with one entry per channel
module demux8_reg #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  demux8_reg_if.slave  bus
);

  logic [7:0]            valid_q, valid_d;
  logic [7:0][WIDTH-1:0] data_q, data_d;
  logic                  in_ready;
  logic                  accept;

  // Target slot can take a new entry if it is empty or being drained this cycle
  always_comb begin
    in_ready = 1'b0;
    accept   = 1'b0;
    in_ready = !flush && (!valid_q[bus.in_sel] || bus.out_ready[bus.in_sel]);
    accept   = bus.in_valid && in_ready;
  end

  // Next state: drains clear, accept loads (winning over a same-cycle drain), flush clears all
  always_comb begin
    valid_d = valid_q & ~bus.out_ready;
    data_d  = data_q;
    if (accept) begin
      valid_d[bus.in_sel] = 1'b1;
      data_d[bus.in_sel]  = bus.in_data;
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  // Channel registers; data is kept on drain and flush, only reset zeroes it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.busy      = |valid_q;

endmodule
